// File: rtl/peak_detect_if.sv
// Sample stream from the slope stage into peak_detect: qualifier, sample and
// the three slope flags (lt = rising, gt = falling, eq = flat).
interface peak_detect_if #(
  parameter int WIDTH = 16
);
  logic             valid;
  logic [WIDTH-1:0] datain;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output valid,
    output datain,
    output eq,
    output lt,
    output gt
  );

  modport slave (
    input valid,
    input datain,
    input eq,
    input lt,
    input gt
  );
endinterface : peak_detect_if

// File: rtl/peak_detect.sv
// Hysteretic peak/valley detector driven by pre-computed slope flags.
// Optional event counter enabled by defining PEAK_DETECT_CNT_EN.
module peak_detect #(
  parameter int WIDTH  = 16,
  parameter int MINRUN = 2,
  parameter int CNTW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  peak_detect_if.slave     smp,
  input  logic             cnt_clr,
  output logic             peak,
  output logic             valley,
  output logic [WIDTH-1:0] ext_out,
  output logic [1:0]       trend,
  output logic [CNTW-1:0]  event_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RISE = 2'b01,
    S_FALL = 2'b10
  } state_e;

  localparam logic [3:0] MINRUN_C = 4'(MINRUN);
  localparam logic [3:0] RUN_MAX  = 4'hF;

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [WIDTH-1:0] ext_val_q, ext_val_d;
  logic [WIDTH-1:0] ext_out_q, ext_out_d;
  logic             peak_q, peak_d;
  logic             valley_q, valley_d;
  // Direction of the run being counted while still in IDLE (1 = rising).
  logic             idle_up_q, idle_up_d;

  logic             flat;
  logic             step_up;
  logic             step_dn;
  logic [3:0]       run_inc;
  logic [3:0]       idle_run;

  // A cycle with eq, or with both lt and gt, carries no usable direction.
  assign flat    = smp.eq | (smp.lt & smp.gt);
  assign step_up = smp.valid & ~flat & smp.lt;
  assign step_dn = smp.valid & ~flat & smp.gt;
  assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + 4'd1;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    run_d     = run_q;
    ext_val_d = ext_val_q;
    ext_out_d = ext_out_q;
    idle_up_d = idle_up_q;
    peak_d    = 1'b0;
    valley_d  = 1'b0;
    idle_run  = 4'd1;

    unique case (state_q)
      S_IDLE: begin
        if (step_up || step_dn) begin
          // Continue the run only if it keeps the same direction.
          if (run_q != 4'd0 && idle_up_q == step_up) begin
            idle_run = run_inc;
          end
          idle_up_d = step_up;
          if (idle_run == MINRUN_C) begin
            state_d   = step_up ? S_RISE : S_FALL;
            ext_val_d = smp.datain;
            run_d     = 4'd0;
          end else begin
            run_d = idle_run;
          end
        end
      end

      S_RISE: begin
        if (step_up) begin
          ext_val_d = smp.datain;
          run_d     = 4'd0;
        end else if (step_dn) begin
          if (run_inc == MINRUN_C) begin
            peak_d    = 1'b1;
            ext_out_d = ext_val_q;
            ext_val_d = smp.datain;
            run_d     = 4'd0;
            state_d   = S_FALL;
          end else begin
            run_d = run_inc;
          end
        end
      end

      S_FALL: begin
        if (step_dn) begin
          ext_val_d = smp.datain;
          run_d     = 4'd0;
        end else if (step_up) begin
          if (run_inc == MINRUN_C) begin
            valley_d  = 1'b1;
            ext_out_d = ext_val_q;
            ext_val_d = smp.datain;
            run_d     = 4'd0;
            state_d   = S_RISE;
          end else begin
            run_d = run_inc;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        run_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      run_q     <= 4'd0;
      ext_val_q <= '0;
      ext_out_q <= '0;
      idle_up_q <= 1'b1;
      peak_q    <= 1'b0;
      valley_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      ext_val_q <= ext_val_d;
      ext_out_q <= ext_out_d;
      idle_up_q <= idle_up_d;
      peak_q    <= peak_d;
      valley_q  <= valley_d;
    end
  end

  assign peak    = peak_q;
  assign valley  = valley_q;
  assign ext_out = ext_out_q;
  assign trend   = state_q;

`ifdef PEAK_DETECT_CNT_EN
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Clear has priority over a same-cycle event; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if ((peak_d || valley_d) && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign event_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign event_cnt      = '0;
`endif

endmodule : peak_detect

// File: tb/tb_peak_detect.sv
// Self-checking bench for peak_detect: directed scenarios plus a random walk,
// compared against a sample-level reference model.
module tb_peak_detect;

  localparam int WIDTH  = 16;
  localparam int MINRUN = 2;

`ifdef PEAK_DETECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_clr = 1'b0;

  always #5 clk = ~clk;

  peak_detect_if #(.WIDTH(WIDTH)) smp_if ();

  logic             peak_a, valley_a, peak_b, valley_b;
  logic [WIDTH-1:0] ext_a, ext_b;
  logic [1:0]       trend_a, trend_b;
  logic [7:0]       cnt_a;
  logic [1:0]       cnt_b;

  peak_detect #(.WIDTH(WIDTH), .MINRUN(MINRUN), .CNTW(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .smp       (smp_if),
    .cnt_clr   (cnt_clr),
    .peak      (peak_a),
    .valley    (valley_a),
    .ext_out   (ext_a),
    .trend     (trend_a),
    .event_cnt (cnt_a)
  );

  peak_detect #(.WIDTH(WIDTH), .MINRUN(MINRUN), .CNTW(2)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .smp       (smp_if),
    .cnt_clr   (cnt_clr),
    .peak      (peak_b),
    .valley    (valley_b),
    .ext_out   (ext_b),
    .trend     (trend_b),
    .event_cnt (cnt_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state, expressed in terms of samples and trend.
  int m_trend;      // 0 idle, 1 rising, 2 falling
  int m_run;
  bit m_up;
  int m_ext;
  int m_out;
  bit m_pk, m_vl;
  int m_cnt_a, m_cnt_b;
  int prev_s   = 0;
  bit have_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_trend = 0; m_run = 0; m_up = 1'b1; m_ext = 0; m_out = 0;
    m_pk = 1'b0; m_vl = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic model_step(input bit v, input int s, input bit e, input bit l,
                            input bit g, input bit clr);
    m_pk = 1'b0;
    m_vl = 1'b0;
    if (v && !e && (l ^ g)) begin
      if (m_trend == 0) begin
        m_run = (m_run > 0 && m_up == l) ? m_run + 1 : 1;
        m_up  = l;
        if (m_run == MINRUN) begin
          m_trend = l ? 1 : 2;
          m_ext   = s;
          m_run   = 0;
        end
      end else if ((m_trend == 1) == l) begin
        // Move further in the committed direction: new running extremum.
        m_ext = s;
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == MINRUN) begin
          if (m_trend == 1) m_pk = 1'b1; else m_vl = 1'b1;
          m_out   = m_ext;
          m_ext   = s;
          m_run   = 0;
          m_trend = (m_trend == 1) ? 2 : 1;
        end
      end
    end
    if (clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (m_pk || m_vl) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3)   m_cnt_b++;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".peak"},   32'(peak_a),   32'(m_pk));
    check({tag, ".valley"}, 32'(valley_a), 32'(m_vl));
    check({tag, ".ext"},    32'(ext_a),    32'(m_out));
    check({tag, ".trend"},  32'(trend_a),  32'(m_trend));
    check({tag, ".cnt8"},   32'(cnt_a),    CNT_EN ? 32'(m_cnt_a) : 32'd0);
    check({tag, ".cnt2"},   32'(cnt_b),    CNT_EN ? 32'(m_cnt_b) : 32'd0);
  endtask

  // One clock: derive flags from the sample stream, drive, advance, compare.
  task automatic step(input string tag, input bit v, input int s, input bit clr,
                      input bit both);
    bit e, l, g;
    if (v) begin
      e = !have_prev || (s == prev_s);
      l = have_prev && (s > prev_s);
      g = have_prev && (s < prev_s);
      if (both) begin e = 1'b0; l = 1'b1; g = 1'b1; end
      prev_s    = s;
      have_prev = 1'b1;
    end else begin
      e = 1'($urandom); l = 1'($urandom); g = 1'($urandom);
      s = int'($urandom_range(0, 65535));
    end
    smp_if.valid  = v;
    smp_if.datain = s[WIDTH-1:0];
    smp_if.eq     = e;
    smp_if.lt     = l;
    smp_if.gt     = g;
    cnt_clr       = clr;
    model_step(v, s, e, l, g, clr);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic vstep(input string tag, input int s);
    step(tag, 1'b1, s, 1'b0, 1'b0);
  endtask

  // Reset with a live rising stream on the inputs, which must be ignored.
  task automatic do_reset(input string tag, input int n);
    rst_n = 1'b0;
    smp_if.valid = 1'b1; smp_if.lt = 1'b1; smp_if.gt = 1'b0; smp_if.eq = 1'b0;
    smp_if.datain = 16'hABCD;
    cnt_clr = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    model_reset();
    compare_all(tag);
    rst_n = 1'b1;
    smp_if.valid = 1'b0;
  endtask

  int pulses;

  initial begin
    smp_if.valid = 1'b0; smp_if.datain = '0;
    smp_if.eq = 1'b0; smp_if.lt = 1'b0; smp_if.gt = 1'b0;
    model_reset();

    do_reset("rst0", 3);
    check("rst0.ext_const", 32'(ext_a), 32'd0);

    // Clean peak: 10,20,30,40,35,30
    vstep("clean", 10);
    vstep("clean", 20);
    vstep("clean", 30);
    check("clean.rise_after_30", 32'(trend_a), 32'd1);
    vstep("clean", 40);
    vstep("clean", 35);
    check("clean.no_peak_35", 32'(peak_a), 32'd0);
    vstep("clean", 30);
    check("clean.peak", 32'(peak_a), 32'd1);
    check("clean.ext_out", 32'(ext_a), 32'd40);
    check("clean.trend_fall", 32'(trend_a), 32'd2);
    check("clean.cnt", 32'(cnt_a), CNT_EN ? 32'd1 : 32'd0);
    step("clean.idle", 1'b0, 0, 1'b0, 1'b0);
    check("clean.peak_one_cycle", 32'(peak_a), 32'd0);

    // Reset mid-RISE; the partial trend must be forgotten.
    vstep("midrst", 40);
    vstep("midrst", 50);
    check("midrst.in_rise", 32'(trend_a), 32'd1);
    do_reset("midrst.rst", 3);
    check("midrst.trend0", 32'(trend_a), 32'd0);
    check("midrst.nopulse", 32'({peak_a, valley_a}), 32'd0);
    vstep("midrst.after", 60);
    check("midrst.still_idle", 32'(trend_a), 32'd0);
    vstep("midrst.after", 70);
    check("midrst.rise_again", 32'(trend_a), 32'd1);

    // Noise rejection in RISE at 40.
    do_reset("noise.rst", 1);
    vstep("noise", 20);
    vstep("noise", 30);
    vstep("noise", 40);
    check("noise.rise", 32'(trend_a), 32'd1);
    vstep("noise", 38);
    check("noise.no_peak_38", 32'(peak_a), 32'd0);
    vstep("noise", 41);
    vstep("noise", 45);
    vstep("noise", 44);
    vstep("noise", 43);
    check("noise.peak", 32'(peak_a), 32'd1);
    check("noise.ext_out", 32'(ext_a), 32'd45);

    // Plateau, including a contradictory lt+gt cycle treated as flat.
    do_reset("plat.rst", 1);
    vstep("plat", 20);
    vstep("plat", 30);
    vstep("plat", 40);
    pulses = 0;
    vstep("plat", 40);           pulses += int'(peak_a);
    vstep("plat", 40);           pulses += int'(peak_a);
    step("plat.both", 1'b1, 40, 1'b0, 1'b1);
    check("plat.both_no_change", 32'(trend_a), 32'd1);
    vstep("plat", 35);           pulses += int'(peak_a);
    vstep("plat", 30);           pulses += int'(peak_a);
    check("plat.single_peak", 32'(pulses), 32'd1);
    check("plat.ext_out", 32'(ext_a), 32'd40);

    // Valley with valid gating.
    do_reset("val.rst", 1);
    vstep("val", 30);
    vstep("val", 20);
    vstep("val", 10);
    vstep("val", 5);
    check("val.fall", 32'(trend_a), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step("val.gap", 1'b0, 0, 1'b0, 1'b0);
      check("val.gap_trend", 32'(trend_a), 32'd2);
    end
    vstep("val", 8);
    check("val.no_valley_8", 32'(valley_a), 32'd0);
    vstep("val", 12);
    check("val.valley", 32'(valley_a), 32'd1);
    check("val.ext_out", 32'(ext_a), 32'd5);

    // Counter saturation (CNTW=2) and clear priority.
    do_reset("cnt.rst", 1);
    vstep("cnt", 0);
    vstep("cnt", 10);
    vstep("cnt", 20);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin
        vstep("cnt", 10); vstep("cnt", 0);
      end else begin
        vstep("cnt", 10); vstep("cnt", 20);
      end
    end
    check("cnt.sat2", 32'(cnt_b), CNT_EN ? 32'd3 : 32'd0);
    check("cnt.five", 32'(cnt_a), CNT_EN ? 32'd5 : 32'd0);
    vstep("cnt", 10);
    step("cnt.clr", 1'b1, 20, 1'b1, 1'b0);
    check("cnt.clr_event", 32'(valley_a), 32'd1);
    check("cnt.clr_wins_a", 32'(cnt_a), 32'd0);
    check("cnt.clr_wins_b", 32'(cnt_b), 32'd0);

    // Random walk with gaps, clears, contradictory flags and resets.
    do_reset("rnd.rst", 1);
    prev_s = 1000;
    for (int i = 0; i < 600; i++) begin
      int s;
      s = prev_s + int'($urandom_range(0, 8)) - 4;
      if (s < 0) s = 0;
      if (s > 65535) s = 65535;
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd.rst", 2);
      end else begin
        step("rnd", $urandom_range(0, 3) != 0, s, $urandom_range(0, 31) == 0,
             $urandom_range(0, 15) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_peak_detect

// File: doc/peak_detect.md
PEAK_DETECT -- requirements
Module: peak_detect

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the sample width in bits.
REQ-002 SHALL have parameter MINRUN, default 2, meaning the number of consecutive same-direction slope flags needed to commit a trend (legal range 1..15).
REQ-003 SHALL have parameter CNTW, default 8, meaning the event counter width in bits.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, a synchronous active-low reset.
REQ-006 SHALL have port valid, input, 1 bit, qualifying datain/eq/lt/gt for the current cycle.
REQ-007 SHALL have port datain, input, WIDTH bits, the current sample (same sample the slope stage compared).
REQ-008 SHALL have ports eq, lt, gt, input, 1 bit each, the slope flags (lt = rising, gt = falling, eq = flat).
REQ-009 SHALL have port cnt_clr, input, 1 bit, a synchronous clear of event_cnt.
REQ-010 SHALL have port peak, output, 1 bit, a one-cycle pulse on a confirmed maximum.
REQ-011 SHALL have port valley, output, 1 bit, a one-cycle pulse on a confirmed minimum.
REQ-012 SHALL have port ext_out, output, WIDTH bits, the value of the last confirmed extremum, held until the next event.
REQ-013 SHALL have port trend, output, 2 bits: 00 IDLE, 01 RISE, 10 FALL (11 never driven).
REQ-014 SHALL have port event_cnt, output, CNTW bits, a saturating count of peak plus valley pulses.

Function
REQ-015 SHALL implement FSM states IDLE, RISE, FALL, plus a 4-bit run counter (saturating) and ext_val (WIDTH) tracking the running extremum.
REQ-016 SHALL make no state change and drive peak/valley low on any cycle with valid low.
REQ-017 SHALL treat a valid cycle with eq=1, or with lt and gt both 1, as flat: no state, run, or ext_val change.
REQ-018 In IDLE, SHALL count consecutive lt (or gt) flags; on reaching MINRUN, SHALL move to RISE (FALL), set ext_val=datain, clear run, and emit no pulse; a direction change SHALL restart the run at 1.
REQ-019 In RISE, on lt, SHALL set ext_val=datain and clear run; on gt, SHALL increment run.
REQ-020 In RISE, when run reaches MINRUN on gt, SHALL pulse peak, set ext_out=ext_val, set ext_val=datain, clear run, and go to FALL.
REQ-021 FALL SHALL behave symmetrically to RISE: gt updates ext_val and clears run; MINRUN lt flags pulse valley with ext_out=ext_val, then go to RISE.
REQ-022 SHALL register all outputs, with a pulse asserted in the cycle after the clock edge that samples the qualifying flag (latency 1).
REQ-023 SHALL increment event_cnt on each pulse and saturate at all-ones; cnt_clr SHALL win over a simultaneous increment.

Reset
REQ-024 While rst_n is low at a clock edge, SHALL set trend=IDLE, peak=0, valley=0, ext_out=0, event_cnt=0, run=0, ext_val=0.
REQ-025 SHALL abandon any partial run or trend on reset mid-operation; the first valid cycle after release is evaluated from IDLE.

Configuration
REQ-026 With macro PEAK_DETECT_CNT_EN defined, SHALL implement event_cnt and cnt_clr per REQ-023.
REQ-027 Without PEAK_DETECT_CNT_EN, SHALL tie event_cnt to 0, ignore cnt_clr, and instantiate no counter flops.

Verification (MINRUN=2, WIDTH=16, flags consistent with consecutive samples)
REQ-028 SHALL cover reset: rst_n low 3 cycles mid-RISE -> trend=00, ext_out=0, event_cnt=0, no pulse.
REQ-029 SHALL cover a clean peak: samples 10,20,30,40,35,30 -> trend=01 after 30; peak one cycle after 30 is sampled; ext_out=40; trend=10; event_cnt=1.
REQ-030 SHALL cover noise rejection: RISE at 40, then 38,41,45,44,43 -> no pulse at 38; peak after 43 with ext_out=45.
REQ-031 SHALL cover a plateau: RISE to 40, then 40,40,35,30 -> single peak, ext_out=40.
REQ-032 SHALL cover a valley and valid gating: FALL to 5, valid low 4 cycles, then 8,12 -> valley after 12, ext_out=5; no change while valid is low.
REQ-033 SHALL cover the counter with CNTW=2: 5 events -> event_cnt=3; cnt_clr with a same-cycle event -> 0; macro undefined -> event_cnt stays 0 throughout.
